// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the synchronous FIFO slice.
package fifo_pkg;

   localparam int DEFAULT_DATA_WIDTH = 16;
   localparam int DEFAULT_DEPTH      = 8;

   // Pointer carries one extra wrap bit above the address bits.
   function automatic int ptr_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, one registered read port.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         we_i,
   input  logic [$clog2(DEPTH)-1:0]     waddr_i,
   input  logic [DATA_WIDTH-1:0]        wdata_i,
   input  logic                         re_i,
   input  logic [$clog2(DEPTH)-1:0]     raddr_i,
   output logic [DATA_WIDTH-1:0]        rdata_o
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;

   // Storage array; contents are deliberately left uncleared by reset.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // Read data register holds its value between accepted reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_q <= '0;
      end else if (re_i) begin
         rdata_q <= mem_q[raddr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers, combinational full/empty and registered read data.
module sync_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
   parameter int DEPTH      = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  w_en,
   input  logic                  r_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  full,
   output logic                  empty
);

   localparam int PW = ptr_width(DEPTH);
   localparam int AW = PW - 1;

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          wr_acc_s;
   logic          rd_acc_s;

   // Flags are judged on pre-edge pointers, so simultaneous requests resolve cleanly.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);

   // Accept decisions and pointer next-state.
   always_comb begin
      wr_acc_s = w_en & ~full;
      rd_acc_s = r_en & ~empty;
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      if (wr_acc_s) begin
         wptr_d = wptr_q + PW'(1'b1);
      end else begin
         wptr_d = wptr_q;
      end
      if (rd_acc_s) begin
         rptr_d = rptr_q + PW'(1'b1);
      end else begin
         rptr_d = rptr_q;
      end
   end

   // Pointer registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (clk),
      .rst     (rst),
      .we_i    (wr_acc_s),
      .waddr_i (wptr_q[AW-1:0]),
      .wdata_i (data_in),
      .re_i    (rd_acc_s),
      .raddr_i (rptr_q[AW-1:0]),
      .rdata_o (data_out)
   );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed and randomized checks of sync_fifo against a queue-based reference model.
module tb_sync_fifo;

   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        w_en = 1'b0;
   logic        r_en = 1'b0;
   logic [15:0] data_in = 16'h0000;
   logic [15:0] data_out;
   logic        full;
   logic        empty;

   int          errors = 0;
   int          checks = 0;
   logic [15:0] q [$];
   logic [15:0] dout_m = 16'h0000;

   sync_fifo #(.DATA_WIDTH(16), .DEPTH(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .w_en     (w_en),
      .r_en     (r_en),
      .data_in  (data_in),
      .data_out (data_out),
      .full     (full),
      .empty    (empty)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".data_out"}, data_out, dout_m);
      check({tag, ".empty"}, {15'd0, empty}, {15'd0, q.size() == 0});
      check({tag, ".full"},  {15'd0, full},  {15'd0, q.size() == D});
   endtask

   // One clock: drive enables, update the model with pre-edge occupancy, compare after the edge.
   task automatic step(input string tag, input logic w, input logic r, input logic [15:0] d);
      bit was_full;
      bit was_empty;
      w_en    = w;
      r_en    = r;
      data_in = d;
      @(posedge clk);
      was_full  = (q.size() == D);
      was_empty = (q.size() == 0);
      if (r && !was_empty) dout_m = q.pop_front();
      if (w && !was_full) q.push_back(d);
      #1;
      check_all(tag);
   endtask

   initial begin
      // Power-on reset
      #1 rst = 1'b1;
      #2;
      check_all("por");
      @(posedge clk);
      #1 rst = 1'b0;

      // Fill then drain
      for (int i = 1; i <= D; i++) step("fill", 1'b1, 1'b0, 16'(i));
      check("fill.full_after_8", {15'd0, full}, 16'h0001);
      step("overflow", 1'b1, 1'b0, 16'hFFFF);
      for (int i = 1; i <= D; i++) begin
         step("drain", 1'b0, 1'b1, 16'h0000);
         check("drain.order", data_out, 16'(i));
      end

      // Underflow: reads on empty leave everything alone
      for (int i = 0; i < 3; i++) step("underflow", 1'b0, 1'b1, 16'h0000);
      check("underflow.hold", data_out, 16'h0008);
      step("uf_wr", 1'b1, 1'b0, 16'hA5A5);
      step("uf_rd", 1'b0, 1'b1, 16'h0000);
      check("underflow.ptrs", data_out, 16'hA5A5);

      // Wrap-around: reads start 5 edges, then 10 edges, behind the writes
      for (int i = 0; i < 25; i++)
         step("wrap5", i < 20, i >= 5, 16'($urandom));
      for (int i = 0; i < 12; i++) step("wrap5_dr", 1'b0, 1'b1, 16'h0000);
      for (int i = 0; i < 30; i++)
         step("wrap10", i < 20, i >= 10, 16'($urandom));
      for (int i = 0; i < 12; i++) step("wrap10_dr", 1'b0, 1'b1, 16'h0000);

      // Simultaneous read/write with 4 stored
      for (int i = 0; i < 4; i++) step("sim4_fill", 1'b1, 1'b0, 16'(16'h0100 + i));
      for (int i = 0; i < 10; i++) step("sim4", 1'b1, 1'b1, 16'(16'h0200 + i));
      check("sim4.count", 16'(q.size()), 16'd4);
      for (int i = 0; i < 4; i++) step("sim4_dr", 1'b0, 1'b1, 16'h0000);
      check("sim4.last", data_out, 16'h0209);

      // Simultaneous when full: read only
      for (int i = 0; i < D; i++) step("simf_fill", 1'b1, 1'b0, 16'(16'h0300 + i));
      step("simf", 1'b1, 1'b1, 16'hDEAD);
      check("simf.full_drop", {15'd0, full}, 16'h0000);
      check("simf.data", data_out, 16'h0300);
      for (int i = 0; i < D; i++) step("simf_dr", 1'b0, 1'b1, 16'h0000);

      // Simultaneous when empty: write only
      step("sime", 1'b1, 1'b1, 16'hBEEF);
      check("sime.empty_drop", {15'd0, empty}, 16'h0000);
      check("sime.hold", data_out, 16'h0307);
      step("sime_rd", 1'b0, 1'b1, 16'h0000);

      // Random traffic
      for (int i = 0; i < 200; i++)
         step("rand", 1'($urandom), 1'($urandom), 16'($urandom));

      // Asynchronous reset mid-stream with 3 words stored
      while (q.size() > 0) step("pre_rst_dr", 1'b0, 1'b1, 16'h0000);
      for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 1'b0, 16'(16'h0400 + i));
      step("pre_rst_rd", 1'b0, 1'b1, 16'h0000);
      w_en = 1'b0;
      r_en = 1'b0;
      #2 rst = 1'b1;
      q.delete();
      dout_m = 16'h0000;
      #1;
      check_all("async_rst");
      @(posedge clk);
      #1 rst = 1'b0;
      step("post_rst_rd", 1'b0, 1'b1, 16'h0000);
      check("post_rst.dout", data_out, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sync_fifo.md
# sync_fifo

Single-clock first-in/first-out buffer for 16-bit data words. It sits between a producer and a consumer that share one clock. Writes and reads each use an enable pulse. Status flags let both sides avoid overflow and underflow. It is a generic buffering primitive, with no flow-control logic beyond the full and empty flags.

## Interface
Parameters:
- DATA_WIDTH, 16: width of each stored word.
- DEPTH, 8: number of entries. Must be a power of two, at least 2.

Ports, in positional order:
- clk  in  1: single clock. All state changes happen on its rising edge.
- rst  in  1: asynchronous, active-high reset.
- w_en  in  1: write request, sampled on the rising edge of clk.
- r_en  in  1: read request, sampled on the rising edge of clk.
- data_in  in  DATA_WIDTH: word to write. Sampled on the same edge as w_en.
- data_out  out  DATA_WIDTH: registered read data.
- full  out  1: high when DEPTH entries are stored.
- empty  out  1: high when no entries are stored.

## Operation
- Storage is DEPTH × DATA_WIDTH.
- Write pointer and read pointer are each clog2(DEPTH)+1 bits wide. The MSB is a wrap bit.
- Write is accepted when w_en=1 and full=0 at the edge:
  - mem[wptr low bits] <= data_in.
  - wptr increments by 1.
- Read is accepted when r_en=1 and empty=0 at the edge:
  - data_out <= mem[rptr low bits].
  - rptr increments by 1.
- Pointers wrap modulo 2·DEPTH. The low bits wrap modulo DEPTH naturally.
- empty = (wptr == rptr).
- full = (low bits equal) AND (wrap bits differ).
- Both flags are combinational from the pointer registers. They never assert together.
- Write while full is ignored: no memory change, no pointer change, no error flag.
- Read while empty is ignored: data_out holds its value, no pointer change.
- Simultaneous w_en and r_en are judged against the flags from before the edge:
  - Neither full nor empty: both operations are performed and the occupancy is unchanged.
  - Full: only the read is performed and the write is dropped.
  - Empty: only the write is performed, and data_out is not updated that cycle.
- Data order is strictly FIFO. There is no fall-through or bypass from data_in to data_out.
- data_out holds its last read value until the next accepted read.

## Timing
- Reset while rst=1, asynchronous and at any time, including mid-operation:
  - wptr=0, rptr=0.
  - data_out=0.
  - empty=1, full=0.
  - Stored contents are not required to be cleared.
- Write latency: data written at edge N can be read at edge N+1. empty falls immediately after edge N.
- Read latency: data_out is valid right after the edge at which the read was accepted, which is one clock of latency from r_en.
- full rises immediately after the edge of the DEPTH-th write without an intervening read. It falls immediately after the next accepted read.
- Enables are level-sampled. Holding w_en high for k edges writes k words, stopping at full.

## Structure
- Shared package fifo_pkg holds:
  - the default DATA_WIDTH and DEPTH constants;
  - a localparam function computing the pointer width, clog2(DEPTH)+1.
- One sub-module, fifo_mem: a DEPTH × DATA_WIDTH register array with one synchronous write port and a registered read port.
- Pointer and flag logic stays in sync_fifo.

## Test plan
- Reset: assert rst mid-stream with 3 words stored → empty=1, full=0, data_out=0 immediately, without waiting for a clock edge. After release, a read with r_en=1 leaves data_out=0.
- Fill then drain (DEPTH=8):
  - Write 0x0001 through 0x0008 → full=1 after the 8th edge.
  - A 9th write of 0xFFFF is dropped.
  - Eight reads return 0x0001 through 0x0008 in order, then empty=1.
- Underflow: with the FIFO empty, assert r_en for 3 edges → data_out unchanged, pointers unchanged, empty stays 1.
- Wrap-around: do 20 writes of random values interleaved with reads, with the read stream started 5 edges and then 10 edges after the write stream → every read value matches a reference queue. Pointers wrap past DEPTH with no data loss except writes dropped while full.
- Simultaneous read and write:
  - With 4 words stored, w_en and r_en together for 10 edges → count stays 4 and order is preserved.
  - When full, simultaneous w_en and r_en → read only, full then drops to 0.
  - When empty, simultaneous w_en and r_en → write only, empty then drops to 0.
